// File: rtl/trng_pkg.sv
// trng_pkg: shared state encoding, default parameters and helpers for the TRNG sampler
package trng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_COLLECT = 2'd2,
        ST_FAIL    = 2'd3
    } state_e;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_WARMUP_BITS = 256;
    localparam int DEF_RCT_CUTOFF  = 32;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/trng_sync.sv
// trng_sync: two-flop synchroniser for bclk/random plus rising-edge detect on bclk
module trng_sync (
    input  logic clk,
    input  logic resetn,
    input  logic bclk,
    input  logic random,
    output logic bit_evt,
    output logic bit_val
);

    logic [2:0] bclk_q;
    logic [1:0] rnd_q;

    // Shift both TRNG lines into the clk domain; bclk gets a third stage for edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bclk_q <= '0;
            rnd_q  <= '0;
        end else begin
            bclk_q <= {bclk_q[1:0], bclk};
            rnd_q  <= {rnd_q[0], random};
        end
    end

    assign bit_evt = bclk_q[1] & ~bclk_q[2];
    assign bit_val = rnd_q[1];

endmodule

// File: rtl/trng_sampler.sv
// trng_sampler: warm-up, repetition-count health test and word assembly for a TRNG bit stream
module trng_sampler
    import trng_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int WARMUP_BITS = DEF_WARMUP_BITS,
    parameter int RCT_CUTOFF  = DEF_RCT_CUTOFF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             bclk,
    input  logic             random,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             fail,
    output logic [7:0]       overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [15:0]      warm_q, warm_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [7:0]       run_q, run_d;
    logic             fail_q, fail_d;
    logic             valid_q, valid_d;
    logic [7:0]       ovr_q, ovr_d;

    logic             bit_evt, bit_val;
    logic             active, rct_hit, word_done, load;
    logic [7:0]       run_nxt;

    trng_sync u_sync (
        .clk    (clk),
        .resetn (resetn),
        .bclk   (bclk),
        .random (random),
        .bit_evt(bit_evt),
        .bit_val(bit_val)
    );

    // Event qualification, run-length update and word-handoff decisions
    always_comb begin
        active    = bit_evt && en && (state_q == ST_WARMUP || state_q == ST_COLLECT);
        run_nxt   = (run_q != 8'd0 && bit_val == last_q)
                    ? ((run_q == 8'(RCT_CUTOFF)) ? run_q : run_q + 8'd1)
                    : 8'd1;
        rct_hit   = active && (run_nxt == 8'(RCT_CUTOFF));
        word_done = active && !rct_hit && state_q == ST_COLLECT && cnt_q == CW'(WIDTH - 1);
        load      = word_done && (!valid_q || ready);
        data_d    = load ? {shift_q[WIDTH-2:0], bit_val} : data_q;
        valid_d   = load || (valid_q && !ready);
        ovr_d     = (word_done && !load) ? sat_inc8(ovr_q) : ovr_q;
    end

    // Next state for the sequencer, health test and shift register; en low clears a run
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        run_d   = run_q;
        fail_d  = fail_q;
        if (!en) begin
            state_d = ST_IDLE;
            warm_d  = '0;
            shift_d = '0;
            cnt_d   = '0;
            last_d  = 1'b0;
            run_d   = '0;
            fail_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_WARMUP;
                ST_WARMUP: begin
                    if (active) begin
                        last_d = bit_val;
                        run_d  = run_nxt;
                        if (rct_hit) begin
                            fail_d  = 1'b1;
                            state_d = ST_FAIL;
                        end else if (warm_q == 16'(WARMUP_BITS - 1)) begin
                            warm_d  = '0;
                            state_d = ST_COLLECT;
                        end else begin
                            warm_d = warm_q + 16'd1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (active) begin
                        last_d = bit_val;
                        run_d  = run_nxt;
                        if (rct_hit) begin
                            fail_d  = 1'b1;
                            state_d = ST_FAIL;
                        end else begin
                            shift_d = {shift_q[WIDTH-2:0], bit_val};
                            cnt_d   = (cnt_q == CW'(WIDTH - 1)) ? '0 : cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            warm_q  <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            run_q   <= '0;
            fail_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            run_q   <= run_d;
            fail_q  <= fail_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign fail    = fail_q;
    assign overrun = ovr_q;
    assign busy    = (state_q == ST_WARMUP) || (state_q == ST_COLLECT);

endmodule

// File: tb/tb_trng_sampler.sv
// tb_trng_sampler: directed scoreboard bench for trng_sampler
module tb_trng_sampler;

    localparam int W = 8;

    logic         clk, resetn, en, bclk, random, ready;
    logic         valid, fail, busy;
    logic [W-1:0] data;
    logic [7:0]   overrun;

    int           compared   = 0;
    int           mismatched = 0;
    int           vcnt       = 0;
    int           v0;
    logic         pv         = 1'b0;
    logic [W-1:0] pd         = '0;
    logic [W-1:0] q[$];

    trng_sampler #(.WIDTH(W), .WARMUP_BITS(4), .RCT_CUTOFF(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .en     (en),
        .bclk   (bclk),
        .random (random),
        .data   (data),
        .valid  (valid),
        .ready  (ready),
        .fail   (fail),
        .overrun(overrun),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk period; a handshake at the preceding posedge used last sample's valid/data and current ready
    task automatic tick();
        @(negedge clk);
        if (pv && ready && resetn) begin
            compared++;
            assert (q.size() != 0) else begin
                mismatched++;
                $error("FAIL extra_word: observed %0h expected none", pd);
            end
            if (q.size() != 0) check("word", 32'(pd), 32'(q.pop_front()));
        end
        pv = valid;
        pd = data;
        if (valid) vcnt++;
    endtask

    task automatic send_bit(input logic b);
        random = b;
        repeat (4) tick();
        bclk = 1'b1;
        repeat (8) tick();
        bclk = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit push);
        if (push) q.push_back(w);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic warmup();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        en     = 1'b0;
        bclk   = 1'b0;
        random = 1'b0;
        ready  = 1'b1;
        repeat (3) tick();
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_fail", 32'(fail), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        resetn = 1'b1;
        tick();
        en = 1'b1;
        tick();
        check("busy_warmup", 32'(busy), 32'h1);
        warmup();
        check("warmup_no_word", 32'(valid), 32'h0);
        send_word(8'hAA, 1'b1);
        send_word(8'h55, 1'b1);
        check("alt_fail", 32'(fail), 32'h0);
        v0 = vcnt;
        send_word(8'hB2, 1'b1);
        check("b2_valid_cycles", 32'(vcnt - v0), 32'h1);
        ready = 1'b0;
        send_word(8'hC3, 1'b1);
        send_word(8'h3C, 1'b0);
        send_word(8'h96, 1'b0);
        check("hold_overrun", 32'(overrun), 32'h2);
        check("hold_valid", 32'(valid), 32'h1);
        check("hold_data", 32'(data), 32'hC3);
        ready = 1'b1;
        repeat (3) tick();
        check("hold_released", 32'(valid), 32'h0);
        repeat (3) send_word(8'hFF, 1'b1);
        repeat (7) send_bit(1'b1);
        check("rct_31", 32'(fail), 32'h0);
        send_bit(1'b1);
        check("rct_32_fail", 32'(fail), 32'h1);
        check("rct_busy", 32'(busy), 32'h0);
        send_word(8'hAA, 1'b0);
        check("fail_no_word", 32'(valid), 32'h0);
        check("fail_overrun", 32'(overrun), 32'h2);
        en = 1'b0;
        tick();
        check("en_off_fail", 32'(fail), 32'h0);
        check("en_off_busy", 32'(busy), 32'h0);
        en = 1'b1;
        tick();
        warmup();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        resetn = 1'b0;
        tick();
        check("mid_rst_data", 32'(data), 32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_overrun", 32'(overrun), 32'h0);
        check("mid_rst_fail", 32'(fail), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        resetn = 1'b1;
        repeat (2) tick();
        check("rewarm_busy", 32'(busy), 32'h1);
        warmup();
        send_word(8'h5A, 1'b1);
        ready = 1'b0;
        send_word(8'hAA, 1'b1);
        repeat (254) send_word(8'hAA, 1'b0);
        check("ovr_254", 32'(overrun), 32'd254);
        send_word(8'hAA, 1'b0);
        check("ovr_255", 32'(overrun), 32'd255);
        repeat (2) send_word(8'hAA, 1'b0);
        check("ovr_sat", 32'(overrun), 32'd255);
        check("ovr_data", 32'(data), 32'hAA);
        ready = 1'b1;
        repeat (3) tick();
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/trng_sampler.md
# trng_sampler

Controller that sequences a `tinytrng` instance and turns its raw bit stream into handshaked bytes. It synchronises the TRNG's `bclk`/`random` outputs into the system clock domain, discards a warm-up window after enable, and runs a continuous repetition-count health test. It assembles accepted bits into `WIDTH`-bit words for a downstream consumer such as a UART or host bridge, and sits between the `tinytrng` outputs and that consumer in the top level.

## Interface
Parameters:
- `WIDTH`, 8: output word width in bits (2..32).
- `WARMUP_BITS`, 256: bits discarded after each enable (1..65535).
- `RCT_CUTOFF`, 32: run length of identical bits that declares failure (2..255).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `en`  in  1  run request; deassertion aborts and clears failure.
- `bclk`  in  1  TRNG bit clock, asynchronous to `clk`.
- `random`  in  1  TRNG bit, valid around `bclk` rising edge.
- `data`  out  WIDTH  assembled word, MSB = oldest bit.
- `valid`  out  1  `data` holds an unconsumed word.
- `ready`  in  1  consumer accepts `data` when `valid && ready`.
- `fail`  out  1  sticky health-test failure.
- `overrun`  out  8  saturating count of words dropped for lack of `ready`.
- `busy`  out  1  high in WARMUP or COLLECT.

## Operation
- Sync: `bclk` and `random` each pass through two flops, then one further flop on `bclk` for edge detection. A bit event fires on the synced-`bclk` 0→1 transition and takes the synced `random` value from the same stage.
- States:
  - IDLE: no bit processing. Go to WARMUP when `en`=1.
  - WARMUP: count bit events; on the `WARMUP_BITS`-th event go to COLLECT. Bits are discarded, but the health test already runs.
  - COLLECT: shift each bit in; a word is complete after `WIDTH` bits.
  - FAIL: no shifting and no new words; a word already in the output register may still be consumed.
- `en`=0 in any state: go to IDLE next cycle, clear the shift register, bit counter, RCT counter and `fail`. `data`/`valid` and `overrun` are kept.
- RCT: track the last bit and the run length; the run counter saturates at `RCT_CUTOFF`. When the run reaches `RCT_CUTOFF` in WARMUP or COLLECT, set `fail` and go to FAIL. The completing word, if any, is not output.
- Word handoff when a word completes: if `valid`=0, or `valid && ready` in that cycle, load `data` and set `valid`. Otherwise drop the word and increment `overrun`, saturating at 255. The shift counter restarts from 0 either way.
- `valid` clears on `valid && ready` unless a new word loads in the same cycle.
- `busy` = state is WARMUP or COLLECT.

## Timing
- Reset values: `data`=0, `valid`=0, `fail`=0, `overrun`=0, `busy`=0; state IDLE; all sync flops 0.
- Latency: a `bclk` rising edge at the pin is seen as a bit event on the 3rd `clk` edge, ±1 for metastability. The word-completing event sets `valid` one cycle later.
- Minimum `bclk` high and low time: 3 `clk` periods. Faster `bclk` is unsupported and may lose bits.
- `en` rising to WARMUP: 1 cycle. `en` falling to IDLE: 1 cycle, and `fail` clears in that same cycle.
- A bit event in the cycle where `en` falls is ignored.
- Reset asserted mid-word: everything returns to its reset value immediately. No partial word survives.

## Structure
- Shared package `trng_pkg`: state enum (IDLE, WARMUP, COLLECT, FAIL) and default parameter constants.
- One sub-module, `trng_sync`: the 2-flop synchroniser plus edge detector, emitting `bit_evt` and `bit_val`.
- The top level instantiates `tinytrng` and `trng_sampler` side by side. `clk` and `resetn` are shared between them.

## Test plan
- Reset then `en`=1, WIDTH=8, WARMUP_BITS=4, alternating bits on a 1 MHz `bclk` (16 MHz `clk`) → the first 4 bits are dropped; `data`=8'hAA or 8'h55 per phase with `valid`=1; `fail`=0.
- Bit pattern 1,0,1,1,0,0,1,0 after warm-up with `ready`=1 → `data`=8'hB2, `valid` high for exactly 1 cycle.
- `ready`=0 for 3 words → the first word is held; `overrun`=2; `data` unchanged until `ready`.
- 32 consecutive 1 bits with RCT_CUTOFF=32 → `fail`=1 at the 32nd event, state FAIL, no further words. Then `en`=0 → `fail`=0 one cycle later.
- `resetn` pulsed low mid-word → all outputs 0. Re-enable repeats the full warm-up.
- 255 drops, then more drops → `overrun` holds at 255.
